// File: rtl/alu_controller.sv
// alu_controller: sequencing front end for the combinational ALU.
// Accepts one request at a time, holds the ALU inputs for a multicycle
// settle window, captures result/flags and owns the architectural flags
// register that feeds the ALU's FlagsIn.
//
//   state | meaning
//   IDLE  | ready for a request; ALU inputs hold the last operation
//   EXEC  | ALU inputs stable, settle counter running down to capture
//   RESP  | result and flags presented until the consumer takes them
module alu_controller #(
    parameter int L          = 16,
    parameter int P          = 0,
    parameter int ExecCycles = 2
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic         ReqValid,
    output logic         ReqReady,
    input  logic [P:0]   ReqOp,
    input  logic [L-1:0] ReqA,
    input  logic [L-1:0] ReqB,
    output logic         RspValid,
    input  logic         RspReady,
    output logic [L-1:0] RspR,
    output logic [L-1:0] RspFlags,
    input  logic         FlagsClear,
    output logic [L-1:0] Flags,
    output logic [P:0]   AluOperation,
    output logic [L-1:0] AluA,
    output logic [L-1:0] AluB,
    output logic [L-1:0] AluFlagsIn,
    input  logic [L-1:0] AluR,
    input  logic [L-1:0] AluFlagsOut,
    output logic         Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } stateT;

    // Low four bits are the ALU-owned flags; the rest pass through untouched.
    localparam logic [L-1:0] AluFlagMask = {{(L-4){1'b0}}, 4'hF};
    localparam logic [3:0]   SettleLoad  = 4'(ExecCycles - 1);

    stateT      state;
    stateT      stateNext;
    logic [3:0] settleCount;
    logic       legalOp;
    logic       accept;
    logic       capture;
    logic       respDone;

    // Only ops 0 and 1 exist; with a 1-bit op field every encoding is legal.
    if (P == 0) begin : gOpOneBit
        assign legalOp = 1'b1;
    end else begin : gOpWide
        assign legalOp = (ReqOp[P:1] == '0);
    end

    assign ReqReady   = (state == IDLE);
    assign RspValid   = (state == RESP);
    assign Busy       = (state != IDLE);
    assign AluFlagsIn = Flags;

    // State register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode and the per-cycle control strobes.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        capture   = 1'b0;
        respDone  = 1'b0;
        case (state)
            IDLE: begin
                if (ReqValid) begin
                    accept    = 1'b1;
                    stateNext = legalOp ? EXEC : RESP;
                end
            end
            EXEC: begin
                if (settleCount == 4'd0) begin
                    capture   = 1'b1;
                    stateNext = RESP;
                end
            end
            RESP: begin
                if (RspReady) begin
                    respDone  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // ALU input latches and settle counter; ALU inputs change only on accept.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            AluOperation <= '0;
            AluA         <= '0;
            AluB         <= '0;
            settleCount  <= 4'd0;
        end else begin
            if (accept) begin
                AluOperation <= ReqOp;
                AluA         <= ReqA;
                AluB         <= ReqB;
                settleCount  <= SettleLoad;
            end else if (state == EXEC && !capture) begin
                settleCount <= settleCount - 4'd1;
            end
        end
    end

    // Response capture. An illegal op answers with zero and the current flags.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            RspR     <= '0;
            RspFlags <= '0;
        end else begin
            if (accept && !legalOp) begin
                RspR     <= '0;
                RspFlags <= Flags;
            end else if (capture) begin
                RspR     <= AluR;
                RspFlags <= AluFlagsOut;
            end
        end
    end

    // Architectural flags: sticky history from the ALU, low bits clearable.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            Flags <= '0;
        end else begin
            if (capture) begin
                Flags <= FlagsClear ? (AluFlagsOut & ~AluFlagMask) : AluFlagsOut;
            end else if (FlagsClear) begin
                Flags <= Flags & ~AluFlagMask;
            end
        end
    end

endmodule

// File: tb/tb_alu_controller.sv
// Directed and randomized bench for alu_controller. The bench plays the ALU
// and keeps its own model of the flags register and response contents.
module tb_alu_controller;

    localparam int L  = 16;
    localparam int P  = 0;
    localparam int EC = 2;

    logic         Clock = 1'b0;
    logic         nReset;
    logic         ReqValid;
    logic         ReqReady;
    logic [P:0]   ReqOp;
    logic [L-1:0] ReqA;
    logic [L-1:0] ReqB;
    logic         RspValid;
    logic         RspReady;
    logic [L-1:0] RspR;
    logic [L-1:0] RspFlags;
    logic         FlagsClear;
    logic [L-1:0] Flags;
    logic [P:0]   AluOperation;
    logic [L-1:0] AluA;
    logic [L-1:0] AluB;
    logic [L-1:0] AluFlagsIn;
    logic [L-1:0] AluR;
    logic [L-1:0] AluFlagsOut;
    logic         Busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] modelFlags;

    alu_controller #(.L(L), .P(P), .ExecCycles(EC)) dut (
        .Clock(Clock), .nReset(nReset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
        .ReqA(ReqA), .ReqB(ReqB),
        .RspValid(RspValid), .RspReady(RspReady), .RspR(RspR), .RspFlags(RspFlags),
        .FlagsClear(FlagsClear), .Flags(Flags),
        .AluOperation(AluOperation), .AluA(AluA), .AluB(AluB), .AluFlagsIn(AluFlagsIn),
        .AluR(AluR), .AluFlagsOut(AluFlagsOut), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    // ALU behaviour: returns {flags, result}; unaffected flag bits pass through.
    function automatic logic [31:0] aluRef(input logic op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] fin);
        int sa, sb, prod;
        logic [15:0] r, f;
        sa = int'($signed(a));
        sb = int'($signed(b));
        f  = fin;
        r  = 16'h0;
        if (op == 1'b0) begin
            f[2:0] = 3'b000;
            if (sb == 0) begin
                r    = 16'h0;
                f[1] = 1'b1;
            end else if (sa == -32768 && sb == -1) begin
                r    = 16'h8000;
                f[2] = 1'b1;
            end else begin
                r    = 16'(sa / sb);
                f[0] = ((sa % sb) != 0);
            end
        end else begin
            prod = sa * sb;
            r    = 16'(prod);
            f[3] = (prod > 32767) || (prod < -32768);
        end
        return {f, r};
    endfunction

    always_comb {AluFlagsOut, AluR} = aluRef(AluOperation[0], AluA, AluB, AluFlagsIn);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Issue one request and wait for its response; optionally clear flags
    // on the capture edge. Leaves the block in RESP with RspReady low.
    task automatic issue(input logic op, input logic [15:0] a, input logic [15:0] b,
                         input bit clearAtCapture, output logic [31:0] expOut);
        int n;
        int lat;
        expOut   = aluRef(op, a, b, modelFlags);
        ReqOp    = op;
        ReqA     = a;
        ReqB     = b;
        ReqValid = 1'b1;
        n = 0;
        while (!ReqReady && n < 50) begin
            step();
            n++;
        end
        chk("req_ready_timeout", 32'(n < 50), 32'd1);
        step();
        ReqValid = 1'b0;
        chk("busy_after_accept", 32'(Busy), 32'd1);
        chk("alu_a_latched", 32'(AluA), 32'(a));
        chk("alu_b_latched", 32'(AluB), 32'(b));
        chk("alu_op_latched", 32'(AluOperation), 32'(op));
        lat = 0;
        while (!RspValid && lat < 40) begin
            if (clearAtCapture && lat == EC - 1) FlagsClear = 1'b1;
            step();
            FlagsClear = 1'b0;
            lat++;
        end
        chk("latency", 32'(lat), 32'(EC));
        chk("rsp_r", 32'(RspR), 32'(expOut[15:0]));
        chk("rsp_flags", 32'(RspFlags), 32'(expOut[31:16]));
        modelFlags = clearAtCapture ? (expOut[31:16] & ~16'h000F) : expOut[31:16];
        chk("flags_after_capture", 32'(Flags), 32'(modelFlags));
        chk("req_ready_in_resp", 32'(ReqReady), 32'd0);
    endtask

    task automatic finishRsp();
        RspReady = 1'b1;
        step();
        RspReady = 1'b0;
        chk("rsp_valid_dropped", 32'(RspValid), 32'd0);
        chk("req_ready_back", 32'(ReqReady), 32'd1);
        chk("busy_idle", 32'(Busy), 32'd0);
    endtask

    task automatic chkResetState(input string tag);
        chk({tag, "_req_ready"}, 32'(ReqReady), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(RspValid), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_rsp_r"}, 32'(RspR), 32'd0);
        chk({tag, "_rsp_flags"}, 32'(RspFlags), 32'd0);
        chk({tag, "_flags"}, 32'(Flags), 32'd0);
        chk({tag, "_alu_in"}, {AluA, AluB}, 32'd0);
        chk({tag, "_alu_op"}, 32'(AluOperation), 32'd0);
        chk({tag, "_alu_flags_in"}, 32'(AluFlagsIn), 32'd0);
    endtask

    initial begin
        logic [31:0] e;
        logic [15:0] holdR, holdF;
        logic        op;
        logic [15:0] a, b;
        ReqValid   = 1'b0;
        ReqOp      = '0;
        ReqA       = '0;
        ReqB       = '0;
        RspReady   = 1'b0;
        FlagsClear = 1'b0;
        nReset     = 1'b0;
        modelFlags = 16'h0;
        step();
        step();
        chkResetState("reset");
        nReset = 1'b1;
        step();

        // 7 / 2: quotient 3 with remainder
        issue(1'b0, 16'd7, 16'd2, 1'b0, e);
        chk("div_7_2_r", 32'(RspR), 32'd3);
        chk("div_7_2_flags", 32'(Flags), 32'h1);
        finishRsp();

        // -7 * 3: no overflow, remainder bit survives
        issue(1'b1, 16'hFFF9, 16'd3, 1'b0, e);
        chk("mul_neg_r", 32'(RspR), 32'hFFEB);
        chk("mul_neg_flags", 32'(Flags), 32'h1);
        finishRsp();

        // 5 / 0, then clear while the response waits
        issue(1'b0, 16'd5, 16'd0, 1'b0, e);
        chk("div0_bit", 32'(RspFlags[1]), 32'd1);
        FlagsClear = 1'b1;
        step();
        FlagsClear = 1'b0;
        modelFlags = modelFlags & ~16'h000F;
        chk("clear_in_resp_flags", 32'(Flags), 32'(modelFlags));
        chk("clear_in_resp_rspflags", 32'(RspFlags), 32'h2);
        chk("clear_in_resp_valid", 32'(RspValid), 32'd1);
        finishRsp();

        // 0x100 * 0x100 overflows; stall the consumer and poke a second request
        issue(1'b1, 16'h0100, 16'h0100, 1'b0, e);
        chk("mul_ovf_flag", 32'(Flags[3]), 32'd1);
        holdR = RspR;
        holdF = RspFlags;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                ReqValid = 1'b1;
                ReqA     = 16'h1234;
                ReqB     = 16'h0003;
            end
            step();
            chk("stall_valid", 32'(RspValid), 32'd1);
            chk("stall_r", 32'(RspR), 32'(holdR));
            chk("stall_flags", 32'(RspFlags), 32'(holdF));
            chk("stall_req_ready", 32'(ReqReady), 32'd0);
        end
        ReqValid = 1'b0;
        finishRsp();
        chk("stall_no_accept", 32'(AluA), 32'h0100);

        // clear coincides with the capture edge
        issue(1'b0, 16'd7, 16'd2, 1'b1, e);
        chk("clear_capture_flags", 32'(Flags[3:0]), 32'd0);
        chk("clear_capture_rsp0", 32'(RspFlags[0]), 32'd1);
        finishRsp();

        // reset mid-EXEC discards the operation
        ReqOp    = 1'b1;
        ReqA     = 16'd9;
        ReqB     = 16'd9;
        ReqValid = 1'b1;
        step();
        ReqValid = 1'b0;
        chk("pre_reset_busy", 32'(Busy), 32'd1);
        nReset = 1'b0;
        #1;
        chkResetState("midexec_reset");
        @(posedge Clock);
        #1;
        nReset = 1'b1;
        modelFlags = 16'h0;
        for (int i = 0; i < EC + 3; i++) begin
            step();
            chk("no_rsp_after_reset", 32'(RspValid), 32'd0);
        end
        issue(1'b0, 16'd100, 16'd7, 1'b0, e);
        finishRsp();

        // randomized traffic against the flag-history model
        for (int i = 0; i < 40; i++) begin
            op = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                a = 16'($urandom_range(0, 40)) - 16'd20;
                b = 16'($urandom_range(0, 10)) - 16'd5;
            end
            issue(op, a, b, ($urandom_range(0, 4) == 0), e);
            if ($urandom_range(0, 3) == 0) begin
                FlagsClear = 1'b1;
                step();
                FlagsClear = 1'b0;
                modelFlags = modelFlags & ~16'h000F;
                chk("rand_clear_flags", 32'(Flags), 32'(modelFlags));
                chk("rand_clear_rspflags", 32'(RspFlags), 32'(e[31:16]));
            end
            repeat ($urandom_range(0, 2)) step();
            chk("rand_hold_r", 32'(RspR), 32'(e[15:0]));
            finishRsp();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
